key_repeat_queue: RTL and testbench



---
 rtl/key_pkg.sv | 23 ++
 rtl/key_event_fifo.sv | 61 ++++++
 rtl/key_repeat_queue.sv | 134 +++++++++++++
 tb/tb_key_repeat_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types for the key event path: key codes, buffered events, repeat FSM states.
// No logic, so no latency.
// No flow control; the consumers of these types handle backpressure.
package key_pkg;

    localparam int NUM_KEYS = 20;
    localparam int KEY_W    = 5;

    typedef logic [KEY_W-1:0] keycode_t;

    // is_repeat: 0 = fresh press, 1 = auto-repeat ('repeat' is a reserved word)
    typedef struct packed {
        keycode_t code;
        logic     is_repeat;
    } key_event_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEAT     = 2'd2
    } repeat_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through FIFO of key events, DEPTH entries (power of two).
// A push is visible at the head one cycle later; a pop frees its slot on the clock edge.
// A push while full is accepted only if a pop happens in the same cycle; a pop while empty is ignored.
module key_event_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  key_event_t                 push_dat,
    output logic                       full,
    input  logic                       pop,
    output key_event_t                 pop_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    key_event_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop on a full buffer frees the slot the simultaneous push needs.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    // Hold the head at zero while empty so the output is clean after reset.
    assign pop_dat = empty ? key_event_t'('0) : mem[rd_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_repeat_queue.sv
// Turns key strobes into a buffered event stream with hold-to-repeat, delivered valid/ready.
// An event decided in cycle N is at the head in cycle N+1 when the buffer was empty.
// While evt_ready is low events queue up to DEPTH; further events are dropped and overflow sticks.
module key_repeat_queue
    import key_pkg::*;
#(
    parameter int REPEAT_DELAY  = 5_000_000,
    parameter int REPEAT_PERIOD = 1_000_000,
    parameter int DEPTH         = 4,
    parameter int CNT_W         = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           key_code,
    input  logic                       key_strobe,
    input  logic                       key_held,
    output logic [KEY_W-1:0]           evt_code,
    output logic                       evt_repeat,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    repeat_state_t    state;
    repeat_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    keycode_t         code_q;
    keycode_t         code_nxt;
    logic             ev_push;
    key_event_t       ev_dat;
    key_event_t       head;
    logic             fifo_full;
    logic             fifo_empty;

    // Repeat FSM: strobe beats release, release beats counter expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        ev_push   = 1'b0;
        ev_dat    = '0;
        if (key_strobe) begin
            ev_push          = 1'b1;
            ev_dat.code      = key_code;
            ev_dat.is_repeat = 1'b0;
            code_nxt         = key_code;
            cnt_nxt          = '0;
            state_nxt        = WAIT_DELAY;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                end
                WAIT_DELAY: begin
                    if (!key_held) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (cnt == DELAY_LAST) begin
                        ev_push          = 1'b1;
                        ev_dat.code      = code_q;
                        ev_dat.is_repeat = 1'b1;
                        cnt_nxt          = '0;
                        state_nxt        = REPEAT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!key_held) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (cnt == PERIOD_LAST) begin
                        ev_push          = 1'b1;
                        ev_dat.code      = code_q;
                        ev_dat.is_repeat = 1'b1;
                        cnt_nxt          = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM state, repeat counter and latched key code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
        end
    end

    // Sticky drop flag: a push into a full buffer with no pop to make room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ev_push && fifo_full && !evt_ready) begin
            overflow <= 1'b1;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ev_push),
        .push_dat (ev_dat),
        .full     (fifo_full),
        .pop      (evt_ready),
        .pop_dat  (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = head.code;
    assign evt_repeat = head.is_repeat;

endmodule

// File: tb/tb_key_repeat_queue.sv
module tb_key_repeat_queue;
    import key_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key_code;
    logic       key_strobe;
    logic       key_held;
    logic [4:0] evt_code;
    logic       evt_repeat;
    logic       evt_valid;
    logic       evt_ready;
    logic       overflow;
    logic [2:0] fifo_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    key_repeat_queue #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3),
        .DEPTH         (4),
        .CNT_W         (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .key_held   (key_held),
        .evt_code   (evt_code),
        .evt_repeat (evt_repeat),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_code = '0; key_strobe = 1'b0; key_held = 1'b0; evt_ready = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({evt_valid, evt_code, evt_repeat, overflow, fifo_count} !== 11'd0)
            $display("FAIL reset_outputs: got v=%b c=%0d r=%b ovf=%b cnt=%0d, want all 0",
                     evt_valid, evt_code, evt_repeat, overflow, fifo_count);
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== IDLE || dut.cnt !== 24'd0)
            $display("FAIL reset_fsm: got state=%0d cnt=%0d, want 0/0", dut.state, dut.cnt);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    // Short hold: one fresh event, no repeat.
    task automatic test_single_press();
        evt_ready = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                total_cnt++;
                if (evt_valid !== (c == 1))
                    $display("FAIL single_valid c%0d: got %b want %b", c, evt_valid, (c == 1));
                else pass_cnt++;
                if (c == 1) begin
                    total_cnt++;
                    if (evt_code !== 5'd7 || evt_repeat !== 1'b0)
                        $display("FAIL single_event: got {%0d,%b} want {7,0}", evt_code, evt_repeat);
                    else pass_cnt++;
                end
            end
            key_strobe = (c == 0);
            key_code   = (c == 0) ? 5'd7 : 5'd0;
            key_held   = (c <= 3);
            tick();
        end
        total_cnt++;
        if (dut.state !== IDLE)
            $display("FAIL single_idle: got state=%0d want IDLE", dut.state);
        else pass_cnt++;
    endtask

    // Long hold: fresh at 1, repeats at 9, 12, 15, nothing after release.
    task automatic test_repeat();
        logic exp_v;
        evt_ready = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) begin
                exp_v = (c == 1) || (c == 9) || (c == 12) || (c == 15);
                total_cnt++;
                if (evt_valid !== exp_v)
                    $display("FAIL repeat_valid c%0d: got %b want %b", c, evt_valid, exp_v);
                else pass_cnt++;
                if (exp_v) begin
                    total_cnt++;
                    if (evt_code !== 5'd12 || evt_repeat !== (c != 1))
                        $display("FAIL repeat_event c%0d: got {%0d,%b} want {12,%b}",
                                 c, evt_code, evt_repeat, (c != 1));
                    else pass_cnt++;
                end
            end
            key_strobe = (c == 0);
            key_code   = (c == 0) ? 5'd12 : 5'd0;
            key_held   = (c <= 14);
            tick();
        end
    endtask

    // Release before the delay expires: no repeat, counter cleared.
    task automatic test_early_release();
        int extra = 0;
        evt_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 1) begin
                total_cnt++;
                if (evt_valid !== 1'b1 || evt_code !== 5'd5 || evt_repeat !== 1'b0)
                    $display("FAIL early_fresh: got v=%b {%0d,%b} want v=1 {5,0}",
                             evt_valid, evt_code, evt_repeat);
                else pass_cnt++;
            end else if (c > 1 && evt_valid) begin
                extra++;
            end
            key_strobe = (c == 0);
            key_code   = (c == 0) ? 5'd5 : 5'd0;
            key_held   = (c <= 4);
            tick();
        end
        total_cnt++;
        if (extra !== 0)
            $display("FAIL early_no_repeat: got %0d extra events want 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (dut.cnt !== 24'd0 || dut.state !== IDLE)
            $display("FAIL early_counter: got cnt=%0d state=%0d want 0/IDLE", dut.cnt, dut.state);
        else pass_cnt++;
    endtask

    // Five strobes into a stalled buffer: fifth dropped, overflow sticks.
    task automatic test_overflow();
        evt_ready = 1'b0;
        key_held  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                total_cnt++;
                if (fifo_count !== 3'd4 || overflow !== 1'b0)
                    $display("FAIL ovf_full_no_drop: got cnt=%0d ovf=%b want 4/0", fifo_count, overflow);
                else pass_cnt++;
            end
            key_strobe = 1'b1;
            key_code   = 5'(c + 1);
            tick();
        end
        key_strobe = 1'b0;
        key_code   = '0;
        total_cnt++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_after_drop: got cnt=%0d ovf=%b want 4/1", fifo_count, overflow);
        else pass_cnt++;
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (evt_valid !== 1'b1 || evt_code !== 5'(i + 1) || evt_repeat !== 1'b0)
                $display("FAIL ovf_drain%0d: got v=%b {%0d,%b} want v=1 {%0d,0}",
                         i, evt_valid, evt_code, evt_repeat, i + 1);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (evt_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1)
            $display("FAIL ovf_end: got v=%b cnt=%0d ovf=%b want 0/0/1", evt_valid, fifo_count, overflow);
        else pass_cnt++;
    endtask

    // Full buffer with simultaneous push and pop: no drop, new event last.
    task automatic test_full_push_pop();
        rst = 1'b1; evt_ready = 1'b0; key_strobe = 1'b0; key_held = 1'b0;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL fpp_reset: got ovf=%b cnt=%0d want 0/0", overflow, fifo_count);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            key_strobe = 1'b1;
            key_code   = 5'(10 + c);
            tick();
        end
        total_cnt++;
        if (fifo_count !== 3'd4 || evt_code !== 5'd10)
            $display("FAIL fpp_filled: got cnt=%0d head=%0d want 4/10", fifo_count, evt_code);
        else pass_cnt++;
        key_strobe = 1'b1;
        key_code   = 5'd14;
        evt_ready  = 1'b1;
        tick();
        key_strobe = 1'b0;
        key_code   = '0;
        total_cnt++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0)
            $display("FAIL fpp_count: got cnt=%0d ovf=%b want 4/0", fifo_count, overflow);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (evt_valid !== 1'b1 || evt_code !== 5'(11 + i))
                $display("FAIL fpp_order%0d: got v=%b code=%0d want v=1 code=%0d",
                         i, evt_valid, evt_code, 11 + i);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (evt_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL fpp_end: got v=%b ovf=%b want 0/0", evt_valid, overflow);
        else pass_cnt++;
    endtask

    // Reset in REPEAT with events buffered and key still held.
    task automatic test_reset_mid_repeat();
        int stray = 0;
        evt_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            key_strobe = (c == 0);
            key_code   = (c == 0) ? 5'd9 : 5'd0;
            key_held   = 1'b1;
            tick();
        end
        total_cnt++;
        if (fifo_count !== 3'd3 || dut.state !== REPEAT)
            $display("FAIL rmr_pre: got cnt=%0d state=%0d want 3/REPEAT", fifo_count, dut.state);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({evt_valid, evt_code, evt_repeat, overflow, fifo_count} !== 11'd0)
            $display("FAIL rmr_outputs: got v=%b c=%0d r=%b ovf=%b cnt=%0d want all 0",
                     evt_valid, evt_code, evt_repeat, overflow, fifo_count);
        else pass_cnt++;
        evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (evt_valid) stray++;
            tick();
        end
        total_cnt++;
        if (stray !== 0)
            $display("FAIL rmr_silent: got %0d events want 0", stray);
        else pass_cnt++;
        key_strobe = 1'b1;
        key_code   = 5'd3;
        tick();
        key_strobe = 1'b0;
        key_code   = '0;
        key_held   = 1'b0;
        total_cnt++;
        if (evt_valid !== 1'b1 || evt_code !== 5'd3 || evt_repeat !== 1'b0)
            $display("FAIL rmr_new_press: got v=%b {%0d,%b} want v=1 {3,0}", evt_valid, evt_code, evt_repeat);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_repeat();
        test_early_release();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_repeat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
